// File: rtl/button_event_if.sv
// Debounced button level in, single-cycle game events out.
// master: decoder side; slave: consumer side that owns the button level.
interface button_event_if;
   logic pb_debounced;
   logic press_pulse;
   logic release_pulse;
   logic long_press;
   logic repeat_pulse;
   logic double_click;
   logic held;

   modport master (
      input  pb_debounced,
      output press_pulse,
      output release_pulse,
      output long_press,
      output repeat_pulse,
      output double_click,
      output held
   );

   modport slave (
      output pb_debounced,
      input  press_pulse,
      input  release_pulse,
      input  long_press,
      input  repeat_pulse,
      input  double_click,
      input  held
   );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat/double-click pulses.
// Ports: clk, rst_n (async active-low), bus (button_event_if.master).
module button_event_decoder #(
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000,
   parameter int unsigned DCLICK_CYCLES = 25_000_000,
   parameter int unsigned CNT_WIDTH     = 27
) (
   input logic           clk,
   input logic           rst_n,
   button_event_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LONG_M1 =
      CNT_WIDTH'(LONG_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RPT_M1 =
      CNT_WIDTH'(REPEAT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_MAX =
      CNT_WIDTH'(DCLICK_CYCLES);
   localparam logic [CNT_WIDTH-1:0] ONE =
      CNT_WIDTH'(1);

   state_t state_q, state_d;

   logic [CNT_WIDTH-1:0] hold_q, hold_d;
   logic [CNT_WIDTH-1:0] rpt_q, rpt_d;
   logic [CNT_WIDTH-1:0] gap_q, gap_d;

   logic armed_q, armed_d;
   logic dc_q, dc_d;
   logic pb_prev_q;

   logic press_q, press_d;
   logic rel_q, rel_d;
   logic long_q, long_d;
   logic rep_q, rep_d;
   logic dclk_q, dclk_d;
   logic held_q, held_d;

   logic pb;
   logic rise;
   logic fall;

   assign pb   = bus.pb_debounced;
   assign rise = pb & ~pb_prev_q;
   assign fall = ~pb & pb_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         rpt_q     <= '0;
         gap_q     <= '0;
         armed_q   <= 1'b0;
         dc_q      <= 1'b0;
         pb_prev_q <= 1'b0;
         press_q   <= 1'b0;
         rel_q     <= 1'b0;
         long_q    <= 1'b0;
         rep_q     <= 1'b0;
         dclk_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rpt_q     <= rpt_d;
         gap_q     <= gap_d;
         armed_q   <= armed_d;
         dc_q      <= dc_d;
         pb_prev_q <= pb;
         press_q   <= press_d;
         rel_q     <= rel_d;
         long_q    <= long_d;
         rep_q     <= rep_d;
         dclk_q    <= dclk_d;
         held_q    <= held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rpt_d   = rpt_q;
      gap_d   = gap_q;
      armed_d = armed_q;
      dc_d    = dc_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      dclk_d  = 1'b0;
      held_d  = held_q;

      // gap_q holds edges since the arming release; a press on
      // an edge where gap_q <= GAP_MAX still qualifies.
      if (armed_q) begin
         if (gap_q == GAP_MAX) begin
            armed_d = 1'b0;
         end else begin
            gap_d = gap_q + ONE;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               press_d = 1'b1;
               held_d  = 1'b1;
               hold_d  = '0;
               dclk_d  = armed_q;
               dc_d    = armed_q;
               armed_d = 1'b0;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               held_d  = 1'b0;
               dc_d    = 1'b0;
               if (!dc_q) begin
                  armed_d = 1'b1;
                  gap_d   = ONE;
               end
            end else if (hold_q == LONG_M1) begin
               // hold_q lags the edge count by one, so this
               // fires on the LONG_CYCLES-th edge after press.
               state_d = LONG;
               long_d  = 1'b1;
               rep_d   = 1'b1;
               rpt_d   = RPT_M1;
            end else begin
               hold_d = hold_q + ONE;
            end
         end
         LONG: begin
            if (fall) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               held_d  = 1'b0;
               dc_d    = 1'b0;
               if (!dc_q) begin
                  armed_d = 1'b1;
                  gap_d   = ONE;
               end
            end else if (rpt_q == '0) begin
               rep_d = 1'b1;
               rpt_d = RPT_M1;
            end else begin
               rpt_d = rpt_q - ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.long_press    = long_q;
   assign bus.repeat_pulse  = rep_q;
   assign bus.double_click  = dclk_q;
   assign bus.held          = held_q;

endmodule
